pio_isr_push: RTL and testbench
===============================

// Module: pio_isr_push
// PURPOSE
//  Input shift register (ISR) of a PIO state machine: the inbound direction complementary to gpio_pins' OUT path.
//  Accepts IN-instruction samples of masked pin data, shifts them into a 32-bit ISR, and pushes completed words
//  to the RX FIFO write port, by autopush threshold or explicit PUSH. Sits between the pin-read path and the RX FIFO.
//  Raises stall to the SM while a push waits on a full FIFO.
// PARAMETERS
//  DATA_W  32  ISR / FIFO word width; only 32 is supported
//  CNT_W   6   shift-count width, range 0..32
// PORTS
//  clock          in   1       single clock, rising edge
//  reset_n        in   1       reset, asynchronous, active-low
//  cfg_shiftRight in   1       1: shift right, new bits enter at MSB; 0: shift left, new bits enter at LSB
//  cfg_autopush   in   1       enable autopush at threshold
//  cfg_pushThresh in   5       push threshold in bits; 0 encodes 32
//  in_valid       in   1       IN instruction executes this cycle
//  in_data        in   32      pin sample, right-justified, already masked
//  in_count       in   6       bits to shift, 1..32; 0 encodes 32
//  push_req       in   1       PUSH instruction executes this cycle
//  push_ifFull    in   1       PUSH acts only if shift count >= threshold
//  push_block     in   1       1: stall while FIFO full; 0: clear ISR and drop the word if FIFO full
//  mov_valid      in   1       MOV ISR: load ISR directly
//  mov_data       in   32      MOV source value
//  fifo_full      in   1       RX FIFO full
//  fifo_wr        out  1       RX FIFO write strobe
//  fifo_wdata     out  32      RX FIFO write data
//  stall          out  1       SM must hold the current instruction
//  isr_value      out  32      current ISR contents
//  shift_count    out  6       current shift count, 0..32
// BEHAVIOUR
//  - Reset (async, reset_n=0): isr=0, count=0, state=IDLE; so fifo_wr=0, stall=0, fifo_wdata=0, all outputs 0.
//  - Two states: IDLE, PUSH.
//    - stall = (state==PUSH).
//    - fifo_wr = (state==PUSH) && !fifo_full.
//    - fifo_wdata = isr.
//    - No combinational path from instruction inputs to outputs.
//  - IDLE accepts at most one command per cycle. Priority mov_valid > in_valid > push_req; lower-priority commands
//    in the same cycle are ignored.
//  - MOV: isr<=mov_data, count<=0. No push.
//  - IN, with n = (in_count==0) ? 32 : in_count and d = in_data masked to n bits:
//    - right shift: isr <= (isr >> n) | (d << (32-n));
//    - left shift:  isr <= (isr << n) | d;
//    - n=32 replaces isr with d;
//    - count <= min(count+n, 32), saturating.
//    - If cfg_autopush && new count >= T (T = cfg_pushThresh==0 ? 32 : cfg_pushThresh): next state is PUSH.
//    - Latency: IN -> fifo_wr is 1 cycle when FIFO is not full.
//  - PUSH in IDLE:
//    - if push_ifFull && count < T: no-op.
//    - else if !push_block && fifo_full: isr<=0, count<=0, no write, no stall.
//    - else: next state is PUSH.
//  - PUSH state:
//    - all instruction inputs are ignored.
//    - the cycle fifo_wr=1: isr<=0, count<=0, state<=IDLE.
//    - stays in PUSH for as long as fifo_full=1.
//  - fifo_full is sampled every cycle. The FIFO must update full by the cycle after a write, so a back-to-back push
//    never double-writes.
//  - Reset mid-PUSH: fifo_wr and stall drop asynchronously and the pending word is lost.
//  - Changes to cfg_* take effect on the next command. Already-pending pushes are not re-evaluated.
// STRUCTURE
//  - pio_pkg holds:
//    - typedef enum logic {ISR_IDLE, ISR_PUSH} isr_state_e;
//    - localparam DATA_W=32;
//    - function thresh_decode (0 -> 32).
//  - One combinational sub-module, pio_shift_merge (isr, d, n, dir -> next isr), which the OSR reuses.
//  - The FSM and counters live in this module.
// TESTING
//  - Reset:
//    - reset_n=0 mid-operation -> isr_value=0, shift_count=0, fifo_wr=0, stall=0 immediately;
//    - release -> IDLE.
//  - Left shift, autopush, T=8:
//    - IN 4'hA (n=4), then IN 4'h5 (n=4), FIFO not full -> next cycle fifo_wr=1, fifo_wdata=32'hA5, stall=1 for 1 cycle;
//    - then count=0.
//  - Right shift, no autopush:
//    - IN 32'h1 n=1 then IN 32'h0 n=1 -> isr=32'h4000_0000, count=2, no write.
//  - Full FIFO, blocking:
//    - autopush trigger with fifo_full=1 for 5 cycles -> stall=1 for 5 cycles, fifo_wr=0, then a single fifo_wr pulse
//      in the cycle full drops.
//  - Nonblocking PUSH with FIFO full:
//    - isr=32'hDEAD, push_block=0 -> no write, stall=0, isr=0, count=0.
//  - Edges:
//    - in_count=0 -> 32-bit replace, count=32;
//    - IN at count=30 with n=4 -> count saturates at 32;
//    - PUSH ifFull at count 3 < T=8 -> no-op;
//    - simultaneous mov_valid+in_valid -> MOV wins.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared types, widths and helpers for the PIO shift-register blocks.
package pio_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic {ISR_IDLE, ISR_PUSH} isr_state_e;

  // 5-bit push threshold; 0 stands for a full 32-bit word.
  function automatic logic [CNT_W-1:0] thresh_decode(input logic [4:0] t);
    return (t == 5'd0) ? CNT_W'(DATA_W) : {1'b0, t};
  endfunction

  // 6-bit IN bit count; 0 stands for 32.
  function automatic logic [CNT_W-1:0] count_decode(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_W'(DATA_W) : c;
  endfunction

  // Shift-count accumulation, saturating at a full word.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > (CNT_W+1)'(DATA_W)) ? CNT_W'(DATA_W) : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pio_isr_push_if.sv
// Bus between the state machine / RX FIFO side and the input shift register.
interface pio_isr_push_if;
  import pio_pkg::*;

  logic              cfg_shiftRight;
  logic              cfg_autopush;
  logic [4:0]        cfg_pushThresh;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_count;
  logic              push_req;
  logic              push_ifFull;
  logic              push_block;
  logic              mov_valid;
  logic [DATA_W-1:0] mov_data;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_wdata;
  logic              stall;
  logic [DATA_W-1:0] isr_value;
  logic [CNT_W-1:0]  shift_count;

  // Master: state machine plus RX FIFO status.
  modport master (
    output cfg_shiftRight, cfg_autopush, cfg_pushThresh,
    output in_valid, in_data, in_count,
    output push_req, push_ifFull, push_block,
    output mov_valid, mov_data, fifo_full,
    input  fifo_wr, fifo_wdata, stall, isr_value, shift_count
  );

  // Slave: the ISR itself.
  modport slave (
    input  cfg_shiftRight, cfg_autopush, cfg_pushThresh,
    input  in_valid, in_data, in_count,
    input  push_req, push_ifFull, push_block,
    input  mov_valid, mov_data, fifo_full,
    output fifo_wr, fifo_wdata, stall, isr_value, shift_count
  );

endinterface

// File: rtl/pio_shift_merge.sv
// Combinational shift-and-merge of n new bits into a 32-bit shift register.
// n is 1..32; the incoming data is masked to n bits here so callers may pass
// unmasked samples. Shared by the input and output shift registers.
module pio_shift_merge
  import pio_pkg::*;
(
  input  logic [DATA_W-1:0] isr_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic [CNT_W-1:0]  n_i,
  input  logic              shift_right_i,
  output logic [DATA_W-1:0] isr_o
);

  logic [CNT_W-1:0]  rem_d;
  logic [DATA_W-1:0] mask_d;
  logic [DATA_W-1:0] dm_d;

  // Shifts of >= DATA_W produce zero, so n=32 naturally degenerates to a replace.
  assign rem_d  = CNT_W'(DATA_W) - n_i;
  assign mask_d = {DATA_W{1'b1}} >> rem_d;
  assign dm_d   = d_i & mask_d;

  // Right: new bits enter at the MSB end. Left: new bits enter at the LSB end.
  always_comb begin
    if (shift_right_i) begin
      isr_o = (isr_i >> n_i) | (dm_d << rem_d);
    end else begin
      isr_o = (isr_i << n_i) | dm_d;
    end
  end

endmodule

// File: rtl/pio_isr_push.sv
// PIO input shift register: collects IN samples, pushes full words into the
// RX FIFO on autopush or PUSH, and stalls the state machine while a push waits.
module pio_isr_push
  import pio_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  pio_isr_push_if.slave  bus
);

  isr_state_e        state_q;
  logic [DATA_W-1:0] isr_q;
  logic [CNT_W-1:0]  count_q;

  logic [CNT_W-1:0]  in_n_d;
  logic [CNT_W-1:0]  thresh_d;
  logic [CNT_W-1:0]  count_sum_d;
  logic [DATA_W-1:0] isr_shift_d;
  logic              write_d;

  assign in_n_d      = count_decode(bus.in_count);
  assign thresh_d    = thresh_decode(bus.cfg_pushThresh);
  assign count_sum_d = sat_add(count_q, in_n_d);

  pio_shift_merge u_merge (
    .isr_i         (isr_q),
    .d_i           (bus.in_data),
    .n_i           (in_n_d),
    .shift_right_i (bus.cfg_shiftRight),
    .isr_o         (isr_shift_d)
  );

  // The only input reaching an output combinationally is fifo_full, so the
  // write strobe drops in the same cycle the FIFO fills.
  assign write_d         = (state_q == ISR_PUSH) && !bus.fifo_full;
  assign bus.fifo_wr     = write_d;
  assign bus.stall       = (state_q == ISR_PUSH);
  assign bus.fifo_wdata  = isr_q;
  assign bus.isr_value   = isr_q;
  assign bus.shift_count = count_q;

  // Command decode in IDLE (MOV > IN > PUSH); in PUSH wait for FIFO space.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ISR_IDLE;
      isr_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ISR_IDLE: begin
          if (bus.mov_valid) begin
            isr_q   <= bus.mov_data;
            count_q <= '0;
          end else if (bus.in_valid) begin
            isr_q   <= isr_shift_d;
            count_q <= count_sum_d;
            if (bus.cfg_autopush && (count_sum_d >= thresh_d)) begin
              state_q <= ISR_PUSH;
            end
          end else if (bus.push_req) begin
            if (bus.push_ifFull && (count_q < thresh_d)) begin
              // Not enough bits collected yet: PUSH is a no-op.
            end else if (!bus.push_block && bus.fifo_full) begin
              // Nonblocking push into a full FIFO drops the word.
              isr_q   <= '0;
              count_q <= '0;
            end else begin
              state_q <= ISR_PUSH;
            end
          end
        end
        ISR_PUSH: begin
          if (write_d) begin
            isr_q   <= '0;
            count_q <= '0;
            state_q <= ISR_IDLE;
          end
        end
        default: state_q <= ISR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_isr_push.sv
// Directed bench for pio_isr_push: a vector table walked one cycle per entry,
// then hand-written sequences for blocking push and reset during a push.
module tb_pio_isr_push;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pio_isr_push_if bus ();

  pio_isr_push dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        mov;
    logic [31:0] mov_data;
    logic        inv;
    logic [31:0] in_data;
    logic [5:0]  in_count;
    logic        push;
    logic        if_full;
    logic        blk;
    logic        right;
    logic        auto_p;
    logic [4:0]  thr;
    logic        full;
    logic [31:0] e_isr;
    logic [5:0]  e_cnt;
    logic        e_stall;
    logic        e_wr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic mov, input logic [31:0] mov_data,
    input logic inv, input logic [31:0] in_data, input logic [5:0] in_count,
    input logic push, input logic if_full, input logic blk,
    input logic right, input logic auto_p, input logic [4:0] thr, input logic full,
    input logic [31:0] e_isr, input logic [5:0] e_cnt, input logic e_stall, input logic e_wr);
    vec_t v;
    v.mov = mov; v.mov_data = mov_data; v.inv = inv; v.in_data = in_data;
    v.in_count = in_count; v.push = push; v.if_full = if_full; v.blk = blk;
    v.right = right; v.auto_p = auto_p; v.thr = thr; v.full = full;
    v.e_isr = e_isr; v.e_cnt = e_cnt; v.e_stall = e_stall; v.e_wr = e_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mov_valid = 0; bus.mov_data = '0; bus.in_valid = 0; bus.in_data = '0;
    bus.in_count = '0; bus.push_req = 0; bus.push_ifFull = 0; bus.push_block = 1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_isr, input logic [5:0] e_cnt,
                           input logic e_stall, input logic e_wr);
    chk({tag, " isr"},   bus.isr_value, e_isr);
    chk({tag, " cnt"},   32'(bus.shift_count), 32'(e_cnt));
    chk({tag, " stall"}, 32'(bus.stall), 32'(e_stall));
    chk({tag, " wr"},    32'(bus.fifo_wr), 32'(e_wr));
    chk({tag, " wdata"}, bus.fifo_wdata, e_isr);
  endtask

  initial begin
    //            mov mdata          inv idata          n      psh iff blk rt au thr  full  e_isr          cnt    st wr
    vecs[0]  = mk(1, 32'h0,          0, 32'h0,          6'd0,  0, 0, 1, 0, 1, 5'd8, 0, 32'h0,          6'd0,  0, 0);
    vecs[1]  = mk(0, 32'h0,          1, 32'hA,          6'd4,  0, 0, 1, 0, 1, 5'd8, 0, 32'hA,          6'd4,  0, 0);
    vecs[2]  = mk(0, 32'h0,          1, 32'h5,          6'd4,  0, 0, 1, 0, 1, 5'd8, 0, 32'hA5,         6'd8,  1, 1);
    vecs[3]  = mk(0, 32'h0,          1, 32'hF,          6'd4,  0, 0, 1, 0, 1, 5'd8, 0, 32'h0,          6'd0,  0, 0);
    vecs[4]  = mk(0, 32'h0,          1, 32'h1,          6'd1,  0, 0, 1, 1, 0, 5'd8, 0, 32'h8000_0000,  6'd1,  0, 0);
    vecs[5]  = mk(0, 32'h0,          1, 32'h0,          6'd1,  0, 0, 1, 1, 0, 5'd8, 0, 32'h4000_0000,  6'd2,  0, 0);
    vecs[6]  = mk(0, 32'h0,          1, 32'hCAFE_BABE,  6'd0,  0, 0, 1, 1, 0, 5'd8, 0, 32'hCAFE_BABE,  6'd32, 0, 0);
    vecs[7]  = mk(1, 32'h0,          0, 32'h0,          6'd0,  0, 0, 1, 0, 0, 5'd8, 0, 32'h0,          6'd0,  0, 0);
    vecs[8]  = mk(0, 32'h0,          1, 32'h3FFF_FFFF,  6'd30, 0, 0, 1, 0, 0, 5'd8, 0, 32'h3FFF_FFFF,  6'd30, 0, 0);
    vecs[9]  = mk(0, 32'h0,          1, 32'hF,          6'd4,  0, 0, 1, 0, 0, 5'd8, 0, 32'hFFFF_FFFF,  6'd32, 0, 0);
    vecs[10] = mk(1, 32'h0,          0, 32'h0,          6'd0,  0, 0, 1, 0, 0, 5'd8, 0, 32'h0,          6'd0,  0, 0);
    vecs[11] = mk(0, 32'h0,          1, 32'h7,          6'd3,  0, 0, 1, 0, 0, 5'd8, 0, 32'h7,          6'd3,  0, 0);
    vecs[12] = mk(0, 32'h0,          0, 32'h0,          6'd0,  1, 1, 1, 0, 0, 5'd8, 0, 32'h7,          6'd3,  0, 0);
    vecs[13] = mk(1, 32'hDEAD,       0, 32'h0,          6'd0,  0, 0, 1, 0, 0, 5'd8, 0, 32'hDEAD,       6'd0,  0, 0);
    vecs[14] = mk(0, 32'h0,          0, 32'h0,          6'd0,  1, 0, 0, 0, 0, 5'd8, 1, 32'h0,          6'd0,  0, 0);
    vecs[15] = mk(1, 32'h1111_2222,  1, 32'hF,          6'd4,  0, 0, 1, 0, 0, 5'd8, 0, 32'h1111_2222,  6'd0,  0, 0);
    vecs[16] = mk(0, 32'h0,          1, 32'hFFFF_FFF3,  6'd4,  1, 0, 1, 0, 0, 5'd8, 0, 32'h1112_2223,  6'd4,  0, 0);
    vecs[17] = mk(0, 32'h0,          0, 32'h0,          6'd0,  1, 0, 1, 0, 0, 5'd8, 0, 32'h1112_2223,  6'd4,  1, 1);
    vecs[18] = mk(0, 32'h0,          0, 32'h0,          6'd0,  0, 0, 1, 0, 0, 5'd8, 0, 32'h0,          6'd0,  0, 0);
    vecs[19] = mk(0, 32'h0,          1, 32'h0BAD_F00D,  6'd0,  0, 0, 1, 0, 1, 5'd0, 0, 32'h0BAD_F00D,  6'd32, 1, 1);
    vecs[20] = mk(0, 32'h0,          0, 32'h0,          6'd0,  0, 0, 1, 0, 1, 5'd0, 0, 32'h0,          6'd0,  0, 0);

    idle_inputs();
    bus.cfg_shiftRight = 0; bus.cfg_autopush = 0; bus.cfg_pushThresh = 5'd8; bus.fifo_full = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 6'd0, 0, 0);
    $display("reset: isr=%h cnt=%0d stall=%0d wr=%0d", bus.isr_value, bus.shift_count, bus.stall, bus.fifo_wr);
    @(negedge clk);
    reset_n = 1;

    // Vector table: one command per cycle, sampled 1 ns after the edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.mov_valid = vecs[i].mov;     bus.mov_data = vecs[i].mov_data;
      bus.in_valid = vecs[i].inv;      bus.in_data = vecs[i].in_data;
      bus.in_count = vecs[i].in_count; bus.push_req = vecs[i].push;
      bus.push_ifFull = vecs[i].if_full; bus.push_block = vecs[i].blk;
      bus.cfg_shiftRight = vecs[i].right; bus.cfg_autopush = vecs[i].auto_p;
      bus.cfg_pushThresh = vecs[i].thr;   bus.fifo_full = vecs[i].full;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_isr, vecs[i].e_cnt, vecs[i].e_stall, vecs[i].e_wr);
      $display("vec %0d: isr=%h cnt=%0d stall=%0d wr=%0d wdata=%h", i, bus.isr_value,
               bus.shift_count, bus.stall, bus.fifo_wr, bus.fifo_wdata);
    end

    // Blocking autopush into a FIFO that stays full for 5 cycles
    @(negedge clk);
    idle_inputs();
    bus.cfg_shiftRight = 0; bus.cfg_autopush = 1; bus.cfg_pushThresh = 5'd8;
    bus.in_valid = 1; bus.in_data = 32'hAB; bus.in_count = 6'd8; bus.fifo_full = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("full%0d stall", c), 32'(bus.stall), 32'd1);
      chk($sformatf("full%0d wr", c), 32'(bus.fifo_wr), 32'd0);
      $display("full cycle %0d: stall=%0d wr=%0d", c, bus.stall, bus.fifo_wr);
      @(negedge clk);
      bus.in_valid = 0;
    end
    bus.fifo_full = 0;
    #1;
    chk("release wr", 32'(bus.fifo_wr), 32'd1);
    chk("release wdata", bus.fifo_wdata, 32'hAB);
    chk("release stall", 32'(bus.stall), 32'd1);
    $display("full released: wr=%0d wdata=%h", bus.fifo_wr, bus.fifo_wdata);
    @(posedge clk);
    #1;
    check_all("after release", 32'h0, 6'd0, 0, 0);
    $display("after release: stall=%0d wr=%0d cnt=%0d", bus.stall, bus.fifo_wr, bus.shift_count);

    // Reset while a push is pending: outputs clear without a clock edge
    @(negedge clk);
    bus.in_valid = 1; bus.in_data = 32'hCD; bus.in_count = 6'd8; bus.fifo_full = 1;
    @(negedge clk);
    bus.in_valid = 0;
    #1;
    chk("pending stall", 32'(bus.stall), 32'd1);
    reset_n = 0;
    #1;
    check_all("async reset", 32'h0, 6'd0, 0, 0);
    $display("async reset: isr=%h cnt=%0d stall=%0d wr=%0d", bus.isr_value, bus.shift_count, bus.stall, bus.fifo_wr);
    @(negedge clk);
    reset_n = 1;
    bus.fifo_full = 0;
    @(posedge clk);
    #1;
    check_all("post reset", 32'h0, 6'd0, 0, 0);
    $display("post reset: stall=%0d wr=%0d", bus.stall, bus.fifo_wr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
